alarm_entry_ctrl: RTL and testbench
===================================

# alarm_entry_ctrl

Keypad-entry controller for the alarm clock datapath. Collects up to four BCD digits from the keypad into an entry buffer, validates them as an HH:MM value, and commits them with a one-cycle load strobe:
- `load_new_alarm` to the alarm time register;
- `load_new_time` to the time-of-day counter.

It also drives the display-select flags, and it discards an abandoned entry after a keypad timeout.

## Interface
Parameters:
- `TIMEOUT_S`, default 10: number of `one_second` pulses without a key before an open entry is discarded. Legal range is 1..63.

Ports:
- `clock` in 1: single clock. All state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `one_second` in 1: one-cycle pulse, once per second.
- `key_valid` in 1: one-cycle strobe; `key` is meaningful while it is high.
- `key` in 4: key code. 0..9 are digits; 10..15 are ignored even with `key_valid`.
- `alarm_button` in 1: level. Its rising edge means "commit as alarm". While high in IDLE it means "show alarm".
- `time_button` in 1: level. Its rising edge means "commit as time".
- `new_ms_hr`, `new_ls_hr`, `new_ms_min`, `new_ls_min` out 4 each: entry buffer contents in BCD.
- `load_new_alarm` out 1: one-cycle commit strobe to the alarm register.
- `load_new_time` out 1: one-cycle commit strobe to the time counter.
- `show_alarm` out 1: display selects the stored alarm time.
- `show_new_time` out 1: display selects the entry buffer.
- `entry_error` out 1: one-cycle pulse when a commit is rejected.

## Operation
- All outputs are registered. Reset values are all 0, state = IDLE, timeout count = 0, button history = 0.
- Edge detection: a rising edge is `button` = 1 while its registered previous value = 0. Both previous values are sampled every cycle in every state.
- A digit is `key_valid` = 1 with `key` ≤ 9. Shifting a digit in means `{ms_hr, ls_hr, ms_min, ls_min}` ← `{ls_hr, ms_min, ls_min, key}`, so the oldest digit drops out after four.

State IDLE:
- `show_alarm` = `alarm_button` level, registered.
- `show_new_time` = 0.
- A digit clears the buffer, shifts that digit in, clears the timeout count, and moves to ENTRY.
- Button edges in IDLE perform no commit.

State ENTRY:
- `show_new_time` = 1, `show_alarm` = 0.
- A digit shifts in and clears the timeout count.
- Each `one_second` pulse increments the timeout count. When the count reaches `TIMEOUT_S`, the buffer clears to 0 and the state returns to IDLE. No strobe is issued.
- `alarm_button` edge: validate the buffer. If valid, pulse `load_new_alarm`; if invalid, pulse `entry_error`. Either way, go to IDLE.
- `time_button` edge: same as above, but pulse `load_new_time` when valid.
- After a commit or error, the buffer keeps its contents until the next entry starts.

Validity rules:
- `ms_hr` ≤ 2.
- If `ms_hr` = 2, then `ls_hr` ≤ 3.
- `ms_min` ≤ 5.
- Fewer than four digits is legal; the leading digits are zero, so "7" means 00:07.

Priority within one ENTRY cycle:
1. Alarm edge.
2. Time edge.
3. Digit.
4. Timeout.

Consequences:
- If both buttons have an edge in the same cycle, only `load_new_alarm` is issued.
- A digit arriving in the same cycle as a button edge is dropped.
- A digit arriving in the same cycle as the final `one_second` wins: it shifts in and the count clears.

Commit strobes and `entry_error` are mutually exclusive and never exceed one cycle.

## Timing
- Commit latency:
  - Edge sampled at clock edge k → the strobe is high in the cycle after edge k, and low again after edge k+1.
  - The buffer outputs are stable during the strobe.
  - The state is IDLE from edge k.
- Digit latency: a digit sampled at edge k appears on the `new_*` outputs after edge k.
- Timeout: with `one_second` pulses and no keys, return to IDLE happens at the edge that samples the `TIMEOUT_S`-th pulse after the last digit.
- Reset mid-entry: at the next edge, all outputs go to 0 and the state goes to IDLE. No strobe is issued.
- A button held through reset produces an edge in the first cycle after reset. In IDLE that edge is harmless.

## Test plan
- Reset, then keys 0,7,3,0, then `alarm_button` edge → `new_*` = 0,7,3,0; `load_new_alarm` high for exactly 1 cycle; `show_new_time` drops to 0.
- Keys 2,4,0,0, then `time_button` edge → `entry_error` pulses once; neither load strobe asserts. Repeat with 2,3,5,9 → `load_new_time` pulses once.
- Keys 1,2,3,4,5 → buffer reads 2,3,4,5. Keys 9 only → buffer reads 0,0,0,9; an alarm commit is accepted.
- `TIMEOUT_S` = 3, key 5, then 3 `one_second` pulses → back to IDLE with the buffer at 0 and no strobe. With a digit arriving alongside the 3rd pulse → still in ENTRY.
- Both button edges in the same cycle during a valid entry → only `load_new_alarm` pulses. A digit arriving in the same cycle as the commit edge is not shifted in.
- Assert `reset` mid-entry after 2 digits → all outputs 0 at the next edge. Holding `alarm_button` in IDLE → `show_alarm` = 1 while held, 0 after release.

Source files
------------

// File: rtl/alarm_entry_ctrl.sv
// Keypad entry controller: collects up to four BCD digits, validates them as HH:MM,
// and commits them to the alarm register or the time counter with one-cycle strobes.
module alarm_entry_ctrl #(
    parameter int TIMEOUT_S = 10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       one_second,
    input  logic       key_valid,
    input  logic [3:0] key,
    input  logic       alarm_button,
    input  logic       time_button,
    output logic [3:0] new_ms_hr,
    output logic [3:0] new_ls_hr,
    output logic [3:0] new_ms_min,
    output logic [3:0] new_ls_min,
    output logic       load_new_alarm,
    output logic       load_new_time,
    output logic       show_alarm,
    output logic       show_new_time,
    output logic       entry_error
);

    typedef enum logic {IDLE, ENTRY} state_t;

    localparam logic [5:0] T_LAST = 6'(TIMEOUT_S - 1);

    state_t     state;
    logic [5:0] tcount;
    logic       alarm_prev;
    logic       time_prev;

    logic digit;
    logic alarm_edge;
    logic time_edge;
    logic entry_ok;

    always_comb begin
        digit      = key_valid && (key <= 4'd9);
        alarm_edge = alarm_button && !alarm_prev;
        time_edge  = time_button && !time_prev;
        entry_ok   = (new_ms_hr <= 4'd2) &&
                     ((new_ms_hr != 4'd2) || (new_ls_hr <= 4'd3)) &&
                     (new_ms_min <= 4'd5);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            tcount         <= '0;
            alarm_prev     <= 1'b0;
            time_prev      <= 1'b0;
            new_ms_hr      <= '0;
            new_ls_hr      <= '0;
            new_ms_min     <= '0;
            new_ls_min     <= '0;
            load_new_alarm <= 1'b0;
            load_new_time  <= 1'b0;
            show_alarm     <= 1'b0;
            show_new_time  <= 1'b0;
            entry_error    <= 1'b0;
        end else begin
            alarm_prev     <= alarm_button;
            time_prev      <= time_button;
            load_new_alarm <= 1'b0;
            load_new_time  <= 1'b0;
            entry_error    <= 1'b0;

            // display flags track the state being entered, so they line up with it
            case (state)
                IDLE: begin
                    show_alarm    <= alarm_button;
                    show_new_time <= 1'b0;
                    if (digit) begin
                        new_ms_hr     <= '0;
                        new_ls_hr     <= '0;
                        new_ms_min    <= '0;
                        new_ls_min    <= key;
                        tcount        <= '0;
                        state         <= ENTRY;
                        show_alarm    <= 1'b0;
                        show_new_time <= 1'b1;
                    end
                end

                ENTRY: begin
                    show_alarm    <= 1'b0;
                    show_new_time <= 1'b1;
                    if (alarm_edge || time_edge) begin
                        state         <= IDLE;
                        show_new_time <= 1'b0;
                        if (!entry_ok)
                            entry_error <= 1'b1;
                        else if (alarm_edge)
                            load_new_alarm <= 1'b1;
                        else
                            load_new_time <= 1'b1;
                    end else if (digit) begin
                        new_ms_hr  <= new_ls_hr;
                        new_ls_hr  <= new_ms_min;
                        new_ms_min <= new_ls_min;
                        new_ls_min <= key;
                        tcount     <= '0;
                    end else if (one_second) begin
                        if (tcount == T_LAST) begin
                            // abandoned entry: discard silently
                            new_ms_hr     <= '0;
                            new_ls_hr     <= '0;
                            new_ms_min    <= '0;
                            new_ls_min    <= '0;
                            tcount        <= '0;
                            state         <= IDLE;
                            show_new_time <= 1'b0;
                        end else begin
                            tcount <= tcount + 6'd1;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alarm_entry_ctrl.sv
// Table-driven bench for alarm_entry_ctrl (TIMEOUT_S = 3): one row per clock edge,
// expected outputs hand-computed, plus a strobe-width sequence.
module tb_alarm_entry_ctrl;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       one_second = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key = 4'd0;
    logic       alarm_button = 1'b0;
    logic       time_button = 1'b0;
    logic [3:0] new_ms_hr, new_ls_hr, new_ms_min, new_ls_min;
    logic       load_new_alarm, load_new_time, show_alarm, show_new_time, entry_error;

    alarm_entry_ctrl #(.TIMEOUT_S(3)) dut (
        .clock(clock), .reset(reset), .one_second(one_second),
        .key_valid(key_valid), .key(key),
        .alarm_button(alarm_button), .time_button(time_button),
        .new_ms_hr(new_ms_hr), .new_ls_hr(new_ls_hr),
        .new_ms_min(new_ms_min), .new_ls_min(new_ls_min),
        .load_new_alarm(load_new_alarm), .load_new_time(load_new_time),
        .show_alarm(show_alarm), .show_new_time(show_new_time),
        .entry_error(entry_error)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        rst;
        logic        kv;
        logic [3:0]  k;
        logic        ab;
        logic        tbtn;
        logic        os;
        logic [15:0] dig;
        logic [4:0]  flags;  // {load_alarm, load_time, show_alarm, show_new_time, error}
    } vec_t;

    vec_t vq[$];
    int   total = 0;
    int   bad = 0;

    task automatic add(input logic rst, input logic kv, input logic [3:0] k,
                       input logic ab, input logic tbtn, input logic os,
                       input logic [15:0] dig, input logic [4:0] flags);
        vec_t v;
        v.rst = rst; v.kv = kv; v.k = k; v.ab = ab; v.tbtn = tbtn; v.os = os;
        v.dig = dig; v.flags = flags;
        vq.push_back(v);
    endtask

    // shorthands: digit key, idle cycle
    task automatic kd(input logic [3:0] k, input logic [15:0] dig, input logic [4:0] fl);
        add(0, 1, k, 0, 0, 0, dig, fl);
    endtask

    function automatic logic [20:0] outs();
        return {new_ms_hr, new_ls_hr, new_ms_min, new_ls_min,
                load_new_alarm, load_new_time, show_alarm, show_new_time, entry_error};
    endfunction

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n_la;
        // ---- vector table ----
        add(1, 0, 0, 0, 0, 0, 16'h0000, 5'b00000);   // reset
        add(0, 0, 0, 0, 0, 0, 16'h0000, 5'b00000);   // idle
        // 0,7,3,0 then alarm commit
        kd(0, 16'h0000, 5'b00010);
        kd(7, 16'h0007, 5'b00010);
        kd(3, 16'h0073, 5'b00010);
        kd(0, 16'h0730, 5'b00010);
        add(0, 0, 0, 1, 0, 0, 16'h0730, 5'b10000);
        add(0, 0, 0, 1, 0, 0, 16'h0730, 5'b00100);   // held in IDLE: show alarm
        add(0, 0, 0, 0, 0, 0, 16'h0730, 5'b00000);
        // 24:00 rejected
        kd(2, 16'h0002, 5'b00010);
        kd(4, 16'h0024, 5'b00010);
        kd(0, 16'h0240, 5'b00010);
        kd(0, 16'h2400, 5'b00010);
        add(0, 0, 0, 0, 1, 0, 16'h2400, 5'b00001);
        add(0, 0, 0, 0, 0, 0, 16'h2400, 5'b00000);
        // 23:59 accepted as time
        kd(2, 16'h0002, 5'b00010);
        kd(3, 16'h0023, 5'b00010);
        kd(5, 16'h0235, 5'b00010);
        kd(9, 16'h2359, 5'b00010);
        add(0, 0, 0, 0, 1, 0, 16'h2359, 5'b01000);
        add(0, 0, 0, 0, 0, 0, 16'h2359, 5'b00000);
        // five digits: oldest drops; key 15 ignored; 23:45 accepted
        kd(1, 16'h0001, 5'b00010);
        kd(2, 16'h0012, 5'b00010);
        kd(3, 16'h0123, 5'b00010);
        kd(4, 16'h1234, 5'b00010);
        kd(5, 16'h2345, 5'b00010);
        kd(15, 16'h2345, 5'b00010);
        add(0, 0, 0, 1, 0, 0, 16'h2345, 5'b10000);
        add(0, 0, 0, 0, 0, 0, 16'h2345, 5'b00000);
        // single digit 9 -> 00:09 accepted
        kd(9, 16'h0009, 5'b00010);
        add(0, 0, 0, 1, 0, 0, 16'h0009, 5'b10000);
        add(0, 0, 0, 0, 0, 0, 16'h0009, 5'b00000);
        // 12:60 rejected (minutes tens > 5)
        kd(1, 16'h0001, 5'b00010);
        kd(2, 16'h0012, 5'b00010);
        kd(6, 16'h0126, 5'b00010);
        kd(0, 16'h1260, 5'b00010);
        add(0, 0, 0, 0, 1, 0, 16'h1260, 5'b00001);
        add(0, 0, 0, 0, 0, 0, 16'h1260, 5'b00000);
        // timeout after 3 pulses
        kd(5, 16'h0005, 5'b00010);
        add(0, 0, 0, 0, 0, 1, 16'h0005, 5'b00010);
        add(0, 0, 0, 0, 0, 1, 16'h0005, 5'b00010);
        add(0, 0, 0, 0, 0, 1, 16'h0000, 5'b00000);
        add(0, 0, 0, 0, 0, 0, 16'h0000, 5'b00000);
        // digit with the 3rd pulse wins and restarts the count
        kd(5, 16'h0005, 5'b00010);
        add(0, 0, 0, 0, 0, 1, 16'h0005, 5'b00010);
        add(0, 0, 0, 0, 0, 1, 16'h0005, 5'b00010);
        add(0, 1, 6, 0, 0, 1, 16'h0056, 5'b00010);
        add(0, 0, 0, 0, 0, 1, 16'h0056, 5'b00010);
        add(0, 0, 0, 0, 0, 1, 16'h0056, 5'b00010);
        add(0, 0, 0, 0, 0, 1, 16'h0000, 5'b00000);
        // both edges + digit in one cycle: alarm only, digit dropped
        kd(1, 16'h0001, 5'b00010);
        kd(2, 16'h0012, 5'b00010);
        add(0, 1, 3, 1, 1, 0, 16'h0012, 5'b10000);
        add(0, 0, 0, 0, 0, 0, 16'h0012, 5'b00000);
        // time edge + digit: digit dropped
        kd(4, 16'h0004, 5'b00010);
        add(0, 1, 8, 0, 1, 0, 16'h0004, 5'b01000);
        add(0, 0, 0, 0, 0, 0, 16'h0004, 5'b00000);
        // button edge in IDLE: no commit
        add(0, 0, 0, 0, 1, 0, 16'h0004, 5'b00000);
        add(0, 0, 0, 0, 0, 0, 16'h0004, 5'b00000);
        // reset mid-entry
        kd(1, 16'h0001, 5'b00010);
        kd(2, 16'h0012, 5'b00010);
        add(1, 0, 0, 0, 0, 0, 16'h0000, 5'b00000);
        add(0, 0, 0, 0, 0, 0, 16'h0000, 5'b00000);
        // alarm button held through reset: edge in IDLE only shows alarm
        add(1, 0, 0, 1, 0, 0, 16'h0000, 5'b00000);
        add(0, 0, 0, 1, 0, 0, 16'h0000, 5'b00100);
        add(0, 0, 0, 1, 0, 0, 16'h0000, 5'b00100);
        add(0, 0, 0, 0, 0, 0, 16'h0000, 5'b00000);

        foreach (vq[i]) begin
            reset = vq[i].rst; key_valid = vq[i].kv; key = vq[i].k;
            alarm_button = vq[i].ab; time_button = vq[i].tbtn; one_second = vq[i].os;
            @(posedge clock); #1;
            total++;
            if (outs() !== {vq[i].dig, vq[i].flags}) begin
                bad++;
                $display("FAIL vec%0d: got dig=%h flags=%b, want dig=%h flags=%b",
                         i, outs()[20:5], outs()[4:0], vq[i].dig, vq[i].flags);
            end
        end

        // ---- hand sequence: commit strobe is exactly one cycle wide ----
        reset = 0; one_second = 0; alarm_button = 0; time_button = 0;
        key_valid = 1;
        foreach (vq[i]) if (i < 4) begin
            key = 4'(i + 1) % 4'd4;  // 1,2,3,0
            @(posedge clock); #1;
        end
        key_valid = 0;
        alarm_button = 1;
        n_la = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clock); #1;
            if (load_new_alarm) n_la++;
            if (c == 0) begin
                alarm_button = 0;
                total++;
                if ({new_ms_hr, new_ls_hr, new_ms_min, new_ls_min} !== 16'h1230) begin
                    bad++;
                    $display("FAIL strobe_buf: got %h want 1230",
                             {new_ms_hr, new_ls_hr, new_ms_min, new_ls_min});
                end
            end
        end
        total++;
        if (n_la != 1) begin
            bad++;
            $display("FAIL strobe_width: got %0d cycles want 1", n_la);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
